// File: rtl/io_map_pkg.sv
// Shared I/O map for the CPU byte bus: register addresses, RAM size and the
// address decode used by the memory-side responder.
package io_map_pkg;

    localparam logic [31:0] IO_UART        = 32'h30000;
    localparam logic [31:0] IO_CLK         = 32'h30004;
    localparam logic [1:0]  IO_SEL_BITS    = 2'b11;
    localparam int          RAM_ADDR_WIDTH = 17;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_UART,
        REG_CNT0,
        REG_CNT1,
        REG_CNT2,
        REG_CNT3,
        REG_NONE
    } io_reg_e;

    localparam logic [17:0] OFF_UART = IO_UART[17:0];
    localparam logic [17:0] OFF_CNT0 = IO_CLK[17:0];
    localparam logic [17:0] OFF_CNT1 = IO_CLK[17:0] + 18'd1;
    localparam logic [17:0] OFF_CNT2 = IO_CLK[17:0] + 18'd2;
    localparam logic [17:0] OFF_CNT3 = IO_CLK[17:0] + 18'd3;

    // Only bits 17:0 take part; everything above is don't-care on this bus.
    function automatic io_reg_e io_decode(input logic [17:0] a);
        io_reg_e r;
        if (a[17:16] != IO_SEL_BITS) begin
            r = REG_RAM;
        end else begin
            case (a)
                OFF_UART: r = REG_UART;
                OFF_CNT0: r = REG_CNT0;
                OFF_CNT1: r = REG_CNT1;
                OFF_CNT2: r = REG_CNT2;
                OFF_CNT3: r = REG_CNT3;
                default:  r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap naturally because
// DEPTH is a power of two. A push into a full FIFO is accepted if a pop happens too.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side end of the CPU byte bus: 128 KB RAM with one-cycle reads plus the
// UART / cycle-counter / program-stop I/O registers at 0x30000 and 0x30004.
module mem_io_responder
    import io_map_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_done,
    output logic        tx_overflow
);

    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_WM = CW'(TX_DEPTH - 2);

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_a;
    io_reg_e               sel;
    logic                  rd_req;
    logic                  wr_req;
    logic                  uart_wr;
    logic                  stop_wr;
    logic [31:0]           cnt;
    logic [31:0]           snap;
    logic                  stop_req;
    logic                  pend;
    logic                  push;
    logic [7:0]            push_data;
    logic                  drop;
    logic                  space;
    logic                  fifo_pop;
    logic [7:0]            fifo_head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_addr;

    assign unused_addr = ^mem_a[31:18];
    assign ram_a       = mem_a[ADDR_WIDTH-1:0];
    assign sel         = io_decode(mem_a[17:0]);
    assign rd_req      = rdy_in && !mem_wr;
    assign wr_req      = rdy_in && mem_wr;
    assign uart_wr     = wr_req && (sel == REG_UART) && (mem_dout != 8'h00);
    assign stop_wr     = wr_req && (sel == REG_CNT0);
    assign rx_ready    = !rst_in && rd_req && (sel == REG_UART) && rx_valid;

    // The UART drains independently of rdy_in, so the pop side is never gated by it.
    assign fifo_pop = tx_valid && tx_ready;
    assign space    = !fifo_full || fifo_pop;
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_head;

    // A held terminator owns the push port; CPU bytes arriving meanwhile are dropped.
    always_comb begin
        push      = 1'b0;
        push_data = mem_dout;
        drop      = 1'b0;
        if (rdy_in) begin
            if (pend) begin
                push      = space;
                push_data = 8'h00;
                drop      = uart_wr;
            end else if (stop_wr) begin
                push      = space;
                push_data = 8'h00;
            end else if (uart_wr) begin
                push = space;
                drop = !space;
            end
        end
    end

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_in) begin
        if (wr_req && sel == REG_RAM) ram[ram_a] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
            snap    <= 32'h0;
        end else if (rd_req) begin
            case (sel)
                REG_RAM:  mem_din <= ram[ram_a];
                REG_UART: mem_din <= rx_valid ? rx_data : 8'h00;
                REG_CNT0: begin
                    mem_din <= cnt[7:0];
                    snap    <= cnt;
                end
                REG_CNT1: mem_din <= snap[15:8];
                REG_CNT2: mem_din <= snap[23:16];
                REG_CNT3: mem_din <= snap[31:24];
                default:  mem_din <= 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt            <= 32'h0;
            stop_req       <= 1'b0;
            pend           <= 1'b0;
            io_buffer_full <= 1'b0;
            prog_done      <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            cnt            <= cnt + 32'd1;
            io_buffer_full <= (fifo_count >= FULL_WM);
            prog_done      <= prog_done || (stop_req && fifo_empty && !pend);
            if (drop) tx_overflow <= 1'b1;
            if (stop_wr) stop_req <= 1'b1;
            if (rdy_in) begin
                if (pend && space)
                    pend <= 1'b0;
                else if (!pend && stop_wr && !space)
                    pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: read results and TX bytes are predicted
// into queues when stimulus is driven and checked when the DUT produces them.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_done;
    logic        tx_overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  txq [$];
    logic [7:0]  rq  [$];
    logic        rd_pend = 1'b0;
    logic [31:0] mcnt = 32'h0;

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .prog_done      (prog_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle counter: zero in reset, +1 on every other edge.
    always @(posedge clk_in) mcnt <= rst_in ? 32'h0 : mcnt + 32'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: compare the previous read's data, then drive the next request.
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [7:0] d, input logic chk, input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk_in);
        if (rd_pend) begin
            e = rq.pop_front();
            check("mem_din", {24'h0, mem_din}, {24'h0, e});
            rd_pend = 1'b0;
        end
        rdy_in   = r;
        mem_wr   = w;
        mem_a    = a;
        mem_dout = d;
        if (!w && chk) begin
            rq.push_back(exp);
            rd_pend = 1'b1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        step(1'b1, 1'b0, a, 8'h00, 1'b1, exp);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
    endtask

    // TX monitor: a handshake seen mid-cycle pops the head at the next edge.
    always begin
        logic [7:0] e;
        @(negedge clk_in);
        #2;
        if (!rst_in && tx_valid && tx_ready) begin
            if (txq.size() == 0) begin
                check("tx_unexpected", {31'h0, tx_valid}, 32'h0);
            end else begin
                e = txq.pop_front();
                check("tx_data", {24'h0, tx_data}, {24'h0, e});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        mem_a    = 32'h30000;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        tx_ready = 1'b0;
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_mem_din", {24'h0, mem_din}, 32'h0);
        check("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_prog_done", {31'h0, prog_done}, 32'h0);
        check("rst_overflow", {31'h0, tx_overflow}, 32'h0);
        rx_valid = 1'b0;
        mem_a    = 32'h0;
        rst_in   = 1'b0;

        // RAM write/read, decode aliasing and upper-bit don't-care
        wr(32'h12345, 8'hA5);
        rd(32'h12345, 8'hA5);
        rd(32'h32345, 8'h00);
        wr(32'h00010, 8'h3C);
        rd(32'h20010, 8'h3C);
        rd(32'hFFFC0010, 8'h3C);

        // rdy_in low: write suppressed, mem_din frozen
        step(1'b0, 1'b1, 32'h10, 8'h77, 1'b0, 8'h00);
        step(1'b0, 1'b0, 32'h12345, 8'h00, 1'b1, 8'h3C);
        rd(32'h10, 8'h3C);

        // RX reads and the combinational pop strobe
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        rd(32'h30000, 8'h5A);
        #1 check("rx_ready_pulse", {31'h0, rx_ready}, 32'h1);
        step(1'b0, 1'b0, 32'h30000, 8'h00, 1'b1, 8'h5A);
        #1 check("rx_ready_frozen", {31'h0, rx_ready}, 32'h0);
        rx_valid = 1'b0;
        rd(32'h30000, 8'h00);
        #1 check("rx_ready_empty", {31'h0, rx_ready}, 32'h0);
        rd(32'h30008, 8'h00);

        // TX basic: zero bytes are not queued
        tx_ready = 1'b1;
        txq.push_back(8'h41);
        wr(32'h30000, 8'h41);
        wr(32'h30000, 8'h00);
        txq.push_back(8'h42);
        wr(32'h30000, 8'h42);
        repeat (5) idle();
        check("tx_basic_left", txq.size(), 32'h0);
        check("tx_basic_idle", {31'h0, tx_valid}, 32'h0);

        // Fill to capacity with the UART stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            txq.push_back(8'h10 + 8'(i));
            wr(32'h30000, 8'h10 + 8'(i));
            if (i == 5) check("buf_full_low", {31'h0, io_buffer_full}, 32'h0);
            if (i == 7) check("buf_full_high", {31'h0, io_buffer_full}, 32'h1);
        end
        check("overflow_before", {31'h0, tx_overflow}, 32'h0);
        wr(32'h30000, 8'hEE);
        idle();
        check("overflow_set", {31'h0, tx_overflow}, 32'h1);
        check("full_valid", {31'h0, tx_valid}, 32'h1);
        tx_ready = 1'b1;
        repeat (12) idle();
        check("fill_drained", txq.size(), 32'h0);
        check("buf_full_clear", {31'h0, io_buffer_full}, 32'h0);

        // Snapshot coherence: latch cnt = 0x000000FF, counter keeps running
        for (int g = 0; g < 600 && mcnt != 32'hFE; g++) idle();
        check("cnt_align_bound", mcnt, 32'hFE);
        rd(32'h30004, 8'hFF);
        rd(32'h30005, 8'h00);
        rd(32'h30006, 8'h00);
        rd(32'h30007, 8'h00);
        idle();

        // Stop sequence: terminator after queued bytes, then prog_done
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            txq.push_back(8'h61 + 8'(i));
            wr(32'h30000, 8'h61 + 8'(i));
        end
        txq.push_back(8'h00);
        wr(32'h30004, 8'h99);
        idle();
        check("stop_not_done", {31'h0, prog_done}, 32'h0);
        tx_ready = 1'b1;
        for (int k = 0; k < 20 && tx_valid; k++) idle();
        check("stop_drain_bound", {31'h0, tx_valid}, 32'h0);
        check("stop_done_late", {31'h0, prog_done}, 32'h0);
        idle();
        check("stop_done", {31'h0, prog_done}, 32'h1);
        check("stop_left", txq.size(), 32'h0);

        // Reset in the middle of a drain
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            txq.push_back(8'h71 + 8'(i));
            wr(32'h30000, 8'h71 + 8'(i));
        end
        tx_ready = 1'b1;
        idle();
        rst_in = 1'b1;
        txq.delete();
        idle();
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_prog_done", {31'h0, prog_done}, 32'h0);
        check("mid_rst_overflow", {31'h0, tx_overflow}, 32'h0);
        check("mid_rst_mem_din", {24'h0, mem_din}, 32'h0);
        rst_in = 1'b0;

        // Stop on a full FIFO: terminator waits in the pending slot
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            txq.push_back(8'h80 + 8'(i));
            wr(32'h30000, 8'h80 + 8'(i));
        end
        txq.push_back(8'h00);
        wr(32'h30004, 8'h01);
        idle();
        check("pend_no_overflow", {31'h0, tx_overflow}, 32'h0);
        tx_ready = 1'b1;
        for (int k = 0; k < 30 && tx_valid; k++) idle();
        check("pend_drain_bound", {31'h0, tx_valid}, 32'h0);
        idle();
        check("pend_done", {31'h0, prog_done}, 32'h1);
        check("pend_left", txq.size(), 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
